// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
//   Bundles the byte handshake, the serializer link and the line-side status of the UART
//   transmit frame controller.
//   Signals:
//     Data_Valid  byte available on P_Data this cycle
//     P_Data      byte to send (the controller uses it for parity only)
//     PAR_EN      1 = append a parity bit
//     PAR_TYP     0 = even parity, 1 = odd parity
//     ser_data    current data bit from the serializer
//     ser_done    serializer presenting its last bit
//     ser_en      serializer shift enable
//     TX_OUT      serial line, idle high
//     Busy        frame in progress
//     Sync_Err    one-cycle pulse on a serializer/controller bit-count mismatch
//   Modports:
//     master  upstream register interface plus serializer (drives the inputs)
//     slave   the frame controller itself
interface uart_tx_ctrl_if;
  logic       Data_Valid;
  logic [7:0] P_Data;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic       TX_OUT;
  logic       Busy;
  logic       Sync_Err;

  modport master (
    output Data_Valid, P_Data, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, TX_OUT, Busy, Sync_Err
  );

  modport slave (
    input  Data_Valid, P_Data, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, TX_OUT, Busy, Sync_Err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   UART transmit frame controller. Accepts a byte via Data_Valid, then sequences the start
//   bit, eight data bits (passed straight through from the serializer), an optional parity
//   bit and a single stop bit onto TX_OUT, one bit per CLK (CLK is the baud clock).
//   A byte offered while in the stop bit starts the next frame with no idle gap; a byte
//   offered in START/DATA/PARITY is dropped.
//   Ports:
//     CLK  TX baud clock, rising edge
//     RST  asynchronous, active-high reset
//     bus  uart_tx_ctrl_if.slave (handshake, serializer link, line and status)
//   Build option:
//     UART_TX_PARITY_EN  defined -> PARITY state and parity logic present.
//                        undefined -> PAR_EN/PAR_TYP ignored, every frame is 10 cycles.
module uart_tx_ctrl (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic       tx_q;
  logic       busy_q;
  logic       ser_en_q;
  logic       sync_err_q;
  logic       last_bit;

  assign last_bit = (bit_cnt_q == 3'd7);

`ifdef UART_TX_PARITY_EN
  logic par_bit_q;
  logic par_en_q;
  logic new_par;

  // Parity of the byte being accepted; only sampled on the acceptance edge.
  assign new_par = bus.PAR_TYP ? ~^bus.P_Data : ^bus.P_Data;
`else
  logic unused_inputs;

  assign unused_inputs = ^{bus.P_Data, bus.PAR_EN, bus.PAR_TYP};
`endif

  // All state and the line/status outputs live in one register block; outputs are loaded
  // with the value they must hold in the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ser_en_q   <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
`endif
    end else begin
      sync_err_q <= 1'b0;
      case (state_q)
        // Idle and the stop bit share acceptance: a waiting byte goes straight to START.
        StIdle, StStop: begin
          ser_en_q <= 1'b0;
          if (bus.Data_Valid) begin
            state_q   <= StStart;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par_bit_q <= new_par;
            par_en_q  <= bus.PAR_EN;
`endif
          end else begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        StStart: begin
          state_q   <= StData;
          bit_cnt_q <= 3'd0;
          ser_en_q  <= 1'b1;
          tx_q      <= 1'b1;  // unused while in DATA, line follows ser_data
        end

        StData: begin
          // The controller's own count decides frame length; ser_done is only cross-checked.
          sync_err_q <= bus.ser_done ^ last_bit;
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (last_bit) begin
            ser_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_q <= StParity;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
`else
            state_q <= StStop;
            tx_q    <= 1'b1;
`endif
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
        end
`endif

        default: begin
          state_q  <= StIdle;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          ser_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Data bits bypass the register so the serializer's bit reaches the line the same cycle.
  assign bus.TX_OUT   = (state_q == StData) ? bus.ser_data : tx_q;
  assign bus.Busy     = busy_q;
  assign bus.ser_en   = ser_en_q;
  assign bus.Sync_Err = sync_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//   Self-checking bench for uart_tx_ctrl. A frame-level model keeps a queue of the line
//   bits each accepted byte must produce; it also plays the serializer. Directed frames
//   add literal expectations for TX_OUT sequences, Busy length, ser_en window and Sync_Err.
module tb_uart_tx_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

`ifdef UART_TX_PARITY_EN
  localparam bit ParityBuilt = 1'b1;
`else
  localparam bit ParityBuilt = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_bit = 7;

  typedef struct {
    logic tx;
    logic is_data;
    int   idx;
  } rec_t;

  rec_t exp_q[$];
  logic exp_sync = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [7:0] d, input logic odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back('{tx: 1'b0, is_data: 1'b0, idx: -1});
    for (int i = 0; i < 8; i++) exp_q.push_back('{tx: d[i], is_data: 1'b1, idx: i});
    if (ParityBuilt && pe) exp_q.push_back('{tx: par_of(d, pt), is_data: 1'b0, idx: -1});
    exp_q.push_back('{tx: 1'b1, is_data: 1'b0, idx: -1});
  endtask

  // Model: the front of exp_q is the bit on the line this cycle. A byte is taken only when
  // the line is idle or the bit just finished was the last of a frame.
  always @(posedge CLK or posedge RST) begin
    rec_t r;
    logic s;
    if (RST) begin
      exp_q.delete();
      exp_sync = 1'b0;
    end else begin
      s = 1'b0;
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        if (r.is_data) s = (bus.ser_done != (r.idx == 7));
      end
      exp_sync = s;
      if (exp_q.size() == 0 && bus.Data_Valid) push_frame(bus.P_Data, bus.PAR_EN, bus.PAR_TYP);
    end
  end

  // Serializer stand-in plus the per-cycle compare.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0 && exp_q[0].is_data) begin
      bus.ser_data = exp_q[0].tx;
      bus.ser_done = (exp_q[0].idx == done_bit);
    end else begin
      bus.ser_data = 1'($urandom_range(0, 1));
      bus.ser_done = 1'b0;
    end
    #2;
    if (!RST) begin
      if (exp_q.size() == 0) begin
        chk("tx_idle", 32'(bus.TX_OUT), 32'd1);
        chk("busy_idle", 32'(bus.Busy), 32'd0);
        chk("ser_en_idle", 32'(bus.ser_en), 32'd0);
      end else begin
        chk("tx_frame", 32'(bus.TX_OUT), 32'(exp_q[0].tx));
        chk("busy_frame", 32'(bus.Busy), 32'd1);
        chk("ser_en_frame", 32'(bus.ser_en), 32'(exp_q[0].is_data));
      end
      chk("sync_err", 32'(bus.Sync_Err), 32'(exp_sync));
    end
  end

  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input int n,
                           output logic [15:0] seq, output int nb, output logic [15:0] sen,
                           output int ns);
    seq = '0;
    sen = '0;
    nb  = 0;
    ns  = 0;
    @(negedge CLK);
    bus.Data_Valid = 1'b1;
    bus.P_Data     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    @(negedge CLK);
    // Changed after acceptance: must not affect the frame.
    bus.Data_Valid = 1'b0;
    bus.P_Data     = ~d;
    bus.PAR_EN     = ~pe;
    bus.PAR_TYP    = ~pt;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      seq[i] = bus.TX_OUT;
      sen[i] = bus.ser_en;
      nb += int'(bus.Busy);
      ns += int'(bus.Sync_Err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq;
    logic [15:0] sen;
    int          nb;
    int          ns;

    bus.Data_Valid = 1'b0;
    bus.P_Data     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    #12;
    chk("rst_tx", 32'(bus.TX_OUT), 32'd1);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_ser_en", 32'(bus.ser_en), 32'd0);
    chk("rst_sync", 32'(bus.Sync_Err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_busy", 32'(bus.Busy), 32'd0);

    // 0xA5 even parity
    run_frame(8'hA5, 1'b1, 1'b0, 14, seq, nb, sen, ns);
`ifdef UART_TX_PARITY_EN
    chk("a5_even_seq", 32'(seq[10:0]), 32'(11'b10101001010));
    chk("a5_even_busy", 32'(nb), 32'd11);
`else
    chk("a5_even_seq", 32'(seq[10:0]), 32'(11'b11101001010));
    chk("a5_even_busy", 32'(nb), 32'd10);
`endif
    chk("a5_ser_en", 32'(sen), 32'h01FE);

    // 0xA5 odd parity -> 1; 0x07 odd parity -> 0
    run_frame(8'hA5, 1'b1, 1'b1, 14, seq, nb, sen, ns);
    chk("a5_odd_bit9", 32'(seq[9]), 32'd1);
    run_frame(8'h07, 1'b1, 1'b1, 14, seq, nb, sen, ns);
`ifdef UART_TX_PARITY_EN
    chk("x07_odd_par", 32'(seq[9]), 32'd0);
    chk("x07_odd_busy", 32'(nb), 32'd11);
`else
    chk("x07_stop", 32'(seq[9]), 32'd1);
    chk("x07_busy", 32'(nb), 32'd10);
`endif

    // Parity disabled -> 10-cycle frame
    run_frame(8'h07, 1'b0, 1'b0, 14, seq, nb, sen, ns);
    chk("nopar_seq", 32'(seq[10:0]), 32'(11'b11000001110));
    chk("nopar_busy", 32'(nb), 32'd10);

    // Back-to-back: 0xFF then 0x3C offered in the stop bit; a mid-DATA pulse is dropped
    @(negedge CLK);
    bus.Data_Valid = 1'b1;
    bus.P_Data     = 8'hFF;
    bus.PAR_EN     = 1'b0;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (9) @(negedge CLK);
    chk("b2b_stop_tx", 32'(bus.TX_OUT), 32'd1);
    chk("b2b_stop_busy", 32'(bus.Busy), 32'd1);
    bus.Data_Valid = 1'b1;
    bus.P_Data     = 8'h3C;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    chk("b2b_start_tx", 32'(bus.TX_OUT), 32'd0);
    chk("b2b_start_busy", 32'(bus.Busy), 32'd1);
    repeat (3) @(negedge CLK);
    bus.Data_Valid = 1'b1;
    bus.P_Data     = 8'h00;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (6) @(negedge CLK);
    chk("b2b_end_busy", 32'(bus.Busy), 32'd0);
    chk("b2b_end_tx", 32'(bus.TX_OUT), 32'd1);

    // Serializer raises ser_done on bit 6 instead of bit 7
    done_bit = 6;
    run_frame(8'h5A, 1'b1, 1'b0, 14, seq, nb, sen, ns);
    done_bit = 7;
    chk("sync_pulses", 32'(ns), 32'd2);
`ifdef UART_TX_PARITY_EN
    chk("sync_busy", 32'(nb), 32'd11);
`else
    chk("sync_busy", 32'(nb), 32'd10);
`endif

    // Reset mid-DATA while a 0 data bit is on the line
    @(negedge CLK);
    bus.Data_Valid = 1'b1;
    bus.P_Data     = 8'h00;
    bus.PAR_EN     = 1'b0;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_rst_tx", 32'(bus.TX_OUT), 32'd0);
    chk("pre_rst_ser_en", 32'(bus.ser_en), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(bus.TX_OUT), 32'd1);
    chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
    chk("mid_rst_ser_en", 32'(bus.ser_en), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    chk("post_rst_busy", 32'(bus.Busy), 32'd0);
    chk("post_rst_tx", 32'(bus.TX_OUT), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
